// File: rtl/checker_pkg.sv
// Shared definitions for the checkers board-state engine.
//   CELL_W          width of one board cell
//   OCC_B/RED_B/KING_B  bit positions inside a cell
//   EMPTY/RED_MAN/BLACK_MAN  cell constants
//   state_t         engine state machine encoding
//   cell_idx()      (x,y) -> linear cell index, matching the {x,y} packing
package checker_pkg;

  localparam int CELL_W = 3;
  localparam int OCC_B  = 2;
  localparam int RED_B  = 1;
  localparam int KING_B = 0;

  localparam logic [CELL_W-1:0] EMPTY     = 3'b000;
  localparam logic [CELL_W-1:0] RED_MAN   = 3'b110;
  localparam logic [CELL_W-1:0] BLACK_MAN = 3'b100;

  typedef enum logic [1:0] {INIT, IDLE, CHECK, COMMIT} state_t;

  function automatic int cell_idx(input int x, input int y, input int dim);
    return x * dim + y;
  endfunction

endpackage

// File: rtl/checker_move_check.sv
// Combinational legality check for a single checkers move.
// Inputs : from/to squares {x,y}, the cells at from, to and the midpoint,
//          and whose turn it is.
// Outputs: legal (move may be committed), is_jump (geometry is a 2-step
//          diagonal), mid_idx (square between from and to), promote (the
//          moving piece lands on the opponent's back row).
module checker_move_check
  import checker_pkg::*;
#(
  parameter  int DIM = 8,
  localparam int CW  = $clog2(DIM)
) (
  input  logic [2*CW-1:0]   from,
  input  logic [2*CW-1:0]   to,
  input  logic [CELL_W-1:0] from_cell,
  input  logic [CELL_W-1:0] to_cell,
  input  logic [CELL_W-1:0] mid_cell,
  input  logic              turn_red,
  output logic              legal,
  output logic              is_jump,
  output logic [2*CW-1:0]   mid_idx,
  output logic              promote
);

  localparam logic signed [CW:0] P1 = (CW+1)'(1);
  localparam logic signed [CW:0] M1 = (CW+1)'(-1);
  localparam logic signed [CW:0] P2 = (CW+1)'(2);
  localparam logic signed [CW:0] M2 = (CW+1)'(-2);
  localparam logic [CW-1:0]      Y_TOP = CW'(DIM - 1);

  logic [CW-1:0] fx, fy, tx, ty;
  logic signed [CW:0] dx, dy;
  logic [CW:0] sum_x, sum_y;
  logic red_piece, king, from_ok, to_ok, capture;
  logic step1, step2, dir1, dir2;

  assign fx = from[2*CW-1:CW];
  assign fy = from[CW-1:0];
  assign tx = to[2*CW-1:CW];
  assign ty = to[CW-1:0];

  // One extra bit keeps the deltas signed over the full board range.
  assign dx = $signed({1'b0, tx}) - $signed({1'b0, fx});
  assign dy = $signed({1'b0, ty}) - $signed({1'b0, fy});

  assign red_piece = from_cell[RED_B];
  assign king      = from_cell[KING_B];

  assign from_ok = from_cell[OCC_B] && (red_piece == turn_red);
  assign to_ok   = !to_cell[OCC_B] && !(tx[0] ^ ty[0]);

  // Men move toward the opponent (red up in y, black down); kings both ways.
  assign dir1  = (dy == P1 && (red_piece || king)) || (dy == M1 && (!red_piece || king));
  assign dir2  = (dy == P2 && (red_piece || king)) || (dy == M2 && (!red_piece || king));
  assign step1 = (dx == P1) || (dx == M1);
  assign step2 = (dx == P2) || (dx == M2);

  assign sum_x   = {1'b0, fx} + {1'b0, tx};
  assign sum_y   = {1'b0, fy} + {1'b0, ty};
  assign mid_idx = {sum_x[CW:1], sum_y[CW:1]};

  assign capture = mid_cell[OCC_B] && (mid_cell[RED_B] != red_piece);
  assign is_jump = step2 && dir2;
  assign legal   = from_ok && to_ok && ((step1 && dir1) || (is_jump && capture));
  assign promote = red_piece ? (ty == Y_TOP) : (ty == '0);

endmodule

// File: rtl/checker_board_state.sv
// Registered DIM x DIM checkers board with move validation and commit.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   move_valid/move_ready    request handshake, move_from/move_to {x,y}
//   move_done/move_ok        one-cycle result pulse and its verdict
//   turn_red                 1 while red is to move
//   red_count/black_count    pieces remaining per side
//   game_over                a side has no pieces left; all moves rejected
//   serialized_board         cell i at bits [3i+2:3i], i = {x,y}
//   chain_active             (CHECKER_MULTI_JUMP_EN only) multi-jump pending
// Optional feature macro: CHECKER_MULTI_JUMP_EN
//
// state  | meaning
// INIT   | write starting layout, one cell per cycle
// IDLE   | ready for a move request
// CHECK  | evaluate legality of the latched move
// COMMIT | report result, apply the move if legal
module checker_board_state
  import checker_pkg::*;
#(
  parameter  int DIM       = 8,
  parameter  int INIT_ROWS = 3,
  localparam int CW        = $clog2(DIM),
  localparam int NW        = $clog2(DIM*DIM/2 + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [2*CW-1:0]            move_from,
  input  logic [2*CW-1:0]            move_to,
  output logic                       move_done,
  output logic                       move_ok,
  output logic                       turn_red,
  output logic [NW-1:0]              red_count,
  output logic [NW-1:0]              black_count,
  output logic                       game_over,
  output logic [CELL_W*DIM*DIM-1:0]  serialized_board
`ifdef CHECKER_MULTI_JUMP_EN
  ,
  output logic                       chain_active
`endif
);

  localparam int            NCELL     = DIM * DIM;
  localparam logic [CW-1:0] RED_LIM   = CW'(INIT_ROWS);
  localparam logic [CW-1:0] BLK_LIM   = CW'(DIM - INIT_ROWS);
  localparam logic [NW-1:0] START_CNT = NW'((DIM/2) * INIT_ROWS);
  localparam logic [NW-1:0] CNT_ONE   = NW'(1);
  localparam logic [2*CW-1:0] IDX_ONE = (2*CW)'(1);

  state_t state_q;
  logic [CELL_W-1:0] board_q [NCELL];
  logic [2*CW-1:0] init_idx_q, from_q, to_q, mid_q;
  logic legal_q, jump_q, promote_q;

  logic [CW-1:0] init_x, init_y;
  logic [CELL_W-1:0] init_cell;
  logic chk_legal, chk_jump, chk_promote, chain_ok;
  logic [2*CW-1:0] chk_mid;

  assign init_x = init_idx_q[2*CW-1:CW];
  assign init_y = init_idx_q[CW-1:0];

  always_comb begin
    init_cell = EMPTY;
    if (!(init_x[0] ^ init_y[0])) begin
      if (init_y < RED_LIM)       init_cell = RED_MAN;
      else if (init_y >= BLK_LIM) init_cell = BLACK_MAN;
    end
  end

  checker_move_check #(.DIM(DIM)) u_check (
    .from      (from_q),
    .to        (to_q),
    .from_cell (board_q[from_q]),
    .to_cell   (board_q[to_q]),
    .mid_cell  (board_q[chk_mid]),
    .turn_red  (turn_red),
    .legal     (chk_legal),
    .is_jump   (chk_jump),
    .mid_idx   (chk_mid),
    .promote   (chk_promote)
  );

`ifdef CHECKER_MULTI_JUMP_EN
  logic [3:0] cand_legal, cand_jump, cand_on;
  logic [2*CW-1:0] chain_sq;
  logic more_jump, chain_next;

  // Follow-up jumps are judged against the board as it will look after the
  // current commit: the origin and the captured square read as empty.
  for (genvar k = 0; k < 4; k++) begin : g_cand
    logic [CW:0] lx, ly;
    logic [2*CW-1:0] land, cmid;
    logic [CELL_W-1:0] land_cell, cmid_cell;
    logic unused_prom;

    assign lx = (k % 2 == 1) ? {1'b0, to_q[2*CW-1:CW]} + (CW+1)'(2)
                             : {1'b0, to_q[2*CW-1:CW]} - (CW+1)'(2);
    assign ly = (k / 2 == 1) ? {1'b0, to_q[CW-1:0]} + (CW+1)'(2)
                             : {1'b0, to_q[CW-1:0]} - (CW+1)'(2);
    // A wrap past either edge sets the extra bit.
    assign cand_on[k] = !lx[CW] && !ly[CW];
    assign land = {lx[CW-1:0], ly[CW-1:0]};
    assign land_cell = (land == from_q || land == mid_q) ? EMPTY : board_q[land];
    assign cmid_cell = (cmid == from_q || cmid == mid_q) ? EMPTY : board_q[cmid];

    checker_move_check #(.DIM(DIM)) u_cand (
      .from      (to_q),
      .to        (land),
      .from_cell (board_q[from_q]),
      .to_cell   (land_cell),
      .mid_cell  (cmid_cell),
      .turn_red  (turn_red),
      .legal     (cand_legal[k]),
      .is_jump   (cand_jump[k]),
      .mid_idx   (cmid),
      .promote   (unused_prom)
    );
  end

  assign more_jump  = |(cand_legal & cand_jump & cand_on);
  assign chain_next = jump_q && !(promote_q && !board_q[from_q][KING_B]) && more_jump;
  assign chain_ok   = !chain_active || (chk_jump && from_q == chain_sq);
`else
  assign chain_ok = 1'b1;
`endif

  assign move_ready = (state_q == IDLE);
  assign move_done  = (state_q == COMMIT);
  assign move_ok    = (state_q == COMMIT) && legal_q;
  // Counts are still zero while the layout is being written after reset.
  assign game_over  = (state_q != INIT) && (red_count == '0 || black_count == '0);

  always_comb begin
    serialized_board = '0;
    for (int i = 0; i < NCELL; i++) serialized_board[CELL_W*i +: CELL_W] = board_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      from_q      <= '0;
      to_q        <= '0;
      mid_q       <= '0;
      legal_q     <= 1'b0;
      jump_q      <= 1'b0;
      promote_q   <= 1'b0;
      turn_red    <= 1'b1;
      red_count   <= '0;
      black_count <= '0;
      for (int i = 0; i < NCELL; i++) board_q[i] <= EMPTY;
`ifdef CHECKER_MULTI_JUMP_EN
      chain_active <= 1'b0;
      chain_sq     <= '0;
`endif
    end else begin
      unique case (state_q)
        INIT: begin
          board_q[init_idx_q] <= init_cell;
          red_count           <= START_CNT;
          black_count         <= START_CNT;
          init_idx_q          <= init_idx_q + IDX_ONE;
          if (init_idx_q == '1) state_q <= IDLE;
        end
        IDLE: begin
          if (move_valid) begin
            from_q  <= move_from;
            to_q    <= move_to;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          legal_q   <= chk_legal && !game_over && chain_ok;
          jump_q    <= chk_jump;
          mid_q     <= chk_mid;
          promote_q <= chk_promote;
          state_q   <= COMMIT;
        end
        COMMIT: begin
          if (legal_q) begin
            board_q[to_q]   <= {board_q[from_q][CELL_W-1:1], board_q[from_q][KING_B] | promote_q};
            board_q[from_q] <= EMPTY;
            if (jump_q) begin
              board_q[mid_q] <= EMPTY;
              if (turn_red) black_count <= black_count - CNT_ONE;
              else          red_count   <= red_count - CNT_ONE;
            end
`ifdef CHECKER_MULTI_JUMP_EN
            if (chain_next) begin
              chain_active <= 1'b1;
              chain_sq     <= to_q;
            end else begin
              chain_active <= 1'b0;
              turn_red     <= !turn_red;
            end
`else
            turn_red <= !turn_red;
`endif
          end
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

endmodule
